// File: rtl/uart_cmd_ctrl.sv
// uart_cmd_ctrl: parses framed command bytes from the UART receiver and
// turns them into register-file writes/reads. Write commands are answered
// with an ack byte, read commands with the read data, both queued to the TX
// FIFO. Malformed, errored, timed-out and overrun traffic is counted in
// ERR_CNT, which saturates at 255.
module uart_cmd_ctrl #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4,
    parameter int TIMEOUT    = 1000
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [DATA_WIDTH-1:0] RX_P_DATA,
    input  logic                  RX_D_VLD,
    input  logic                  RX_PAR_ERR,
    input  logic                  RX_STP_ERR,
    output logic [ADDR_WIDTH-1:0] RF_ADDR,
    output logic                  RF_WR_EN,
    output logic [DATA_WIDTH-1:0] RF_WR_DATA,
    output logic                  RF_RD_EN,
    input  logic [DATA_WIDTH-1:0] RF_RD_DATA,
    input  logic                  RF_RD_VLD,
    input  logic                  TX_FULL,
    output logic [DATA_WIDTH-1:0] TX_P_DATA,
    output logic                  TX_WR_EN,
    output logic                  BUSY,
    output logic [7:0]            ERR_CNT
);

    localparam logic [DATA_WIDTH-1:0] CMD_WR   = DATA_WIDTH'(8'hAA);
    localparam logic [DATA_WIDTH-1:0] CMD_RD   = DATA_WIDTH'(8'hBB);
    localparam logic [DATA_WIDTH-1:0] ACK_BYTE = DATA_WIDTH'(8'h5A);
    localparam logic [15:0]           TMO_LIM  = 16'(TIMEOUT);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_WR_ADDR = 3'd1,
        S_WR_DATA = 3'd2,
        S_RD_ADDR = 3'd3,
        S_RD_WAIT = 3'd4,
        S_TX_SEND = 3'd5
    } state_t;

    state_t                state_reg, state_next;
    logic [15:0]           tmo_cnt_reg, tmo_cnt_next;
    logic [ADDR_WIDTH-1:0] addr_latch_reg, addr_latch_next;
    logic [DATA_WIDTH-1:0] hold_reg, hold_next;

    logic [ADDR_WIDTH-1:0] rf_addr_reg, rf_addr_next;
    logic                  rf_wr_en_reg, rf_wr_en_next;
    logic [DATA_WIDTH-1:0] rf_wr_data_reg, rf_wr_data_next;
    logic                  rf_rd_en_reg, rf_rd_en_next;
    logic [DATA_WIDTH-1:0] tx_p_data_reg, tx_p_data_next;
    logic                  tx_wr_en_reg, tx_wr_en_next;
    logic                  busy_reg, busy_next;
    logic [7:0]            err_cnt_reg, err_cnt_next;

    logic byte_err;    // byte arrived with a framing/parity problem
    logic byte_ok;     // clean byte this cycle
    logic timed;       // state is subject to the inter-byte timeout
    logic timeout;     // inter-byte timeout expired this cycle
    logic go;          // no abort condition this cycle
    logic addr_bad;    // address byte has bits beyond the register file
    logic err_event;   // bump ERR_CNT this cycle

    assign byte_err = RX_D_VLD & (RX_PAR_ERR | RX_STP_ERR);
    assign byte_ok  = RX_D_VLD & ~(RX_PAR_ERR | RX_STP_ERR);
    assign timed    = (state_reg == S_WR_ADDR) || (state_reg == S_WR_DATA) ||
                      (state_reg == S_RD_ADDR) || (state_reg == S_RD_WAIT);
    assign timeout  = timed && (tmo_cnt_reg == TMO_LIM);
    assign go       = ~(byte_err | timeout);

    // Out-of-range check only exists when the byte is wider than the address
    generate
        if (DATA_WIDTH > ADDR_WIDTH) begin : g_addr_chk
            assign addr_bad = |RX_P_DATA[DATA_WIDTH-1:ADDR_WIDTH];
        end else begin : g_addr_nochk
            assign addr_bad = 1'b0;
        end
    endgenerate

    // State register, timeout counter and internal latches
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_reg      <= S_IDLE;
            tmo_cnt_reg    <= '0;
            addr_latch_reg <= '0;
            hold_reg       <= '0;
        end else begin
            state_reg      <= state_next;
            tmo_cnt_reg    <= tmo_cnt_next;
            addr_latch_reg <= addr_latch_next;
            hold_reg       <= hold_next;
        end
    end

    // Next-state logic, error events and timeout counter update
    always_comb begin
        state_next   = state_reg;
        err_event    = 1'b0;
        tmo_cnt_next = tmo_cnt_reg;
        if (!go) begin
            // Byte error or timeout: abort once, whatever the state
            state_next = S_IDLE;
            err_event  = 1'b1;
        end else begin
            case (state_reg)
                S_IDLE: begin
                    if (byte_ok) begin
                        if (RX_P_DATA == CMD_WR)      state_next = S_WR_ADDR;
                        else if (RX_P_DATA == CMD_RD) state_next = S_RD_ADDR;
                        else                          err_event  = 1'b1;
                    end
                end
                S_WR_ADDR: begin
                    if (byte_ok) begin
                        if (addr_bad) begin
                            state_next = S_IDLE;
                            err_event  = 1'b1;
                        end else begin
                            state_next = S_WR_DATA;
                        end
                    end
                end
                S_WR_DATA: begin
                    if (byte_ok) state_next = S_TX_SEND;
                end
                S_RD_ADDR: begin
                    if (byte_ok) begin
                        if (addr_bad) begin
                            state_next = S_IDLE;
                            err_event  = 1'b1;
                        end else begin
                            state_next = S_RD_WAIT;
                        end
                    end
                end
                S_RD_WAIT: begin
                    // Bytes here are overruns; read data from the cycle
                    // carrying our own read strobe is not yet valid
                    if (byte_ok) err_event = 1'b1;
                    if (RF_RD_VLD && !rf_rd_en_reg) state_next = S_TX_SEND;
                end
                S_TX_SEND: begin
                    if (byte_ok) err_event = 1'b1;
                    if (!TX_FULL) state_next = S_IDLE;
                end
                default: state_next = S_IDLE;
            endcase
        end

        // Counter runs only while waiting in a timed state; any state change
        // or accepted command byte restarts it
        if (!timed || (state_next != state_reg) ||
            (byte_ok && (state_reg != S_RD_WAIT))) begin
            tmo_cnt_next = '0;
        end else begin
            tmo_cnt_next = tmo_cnt_reg + 16'd1;
        end
    end

    // Output logic: strobes and data for the registered output stage
    always_comb begin
        rf_addr_next    = rf_addr_reg;
        rf_wr_en_next   = 1'b0;
        rf_wr_data_next = rf_wr_data_reg;
        rf_rd_en_next   = 1'b0;
        tx_p_data_next  = tx_p_data_reg;
        tx_wr_en_next   = 1'b0;
        addr_latch_next = addr_latch_reg;
        hold_next       = hold_reg;
        busy_next       = (state_next != S_IDLE);
        err_cnt_next    = err_cnt_reg;
        if (err_event && (err_cnt_reg != 8'hFF)) err_cnt_next = err_cnt_reg + 8'd1;

        if (go) begin
            case (state_reg)
                S_WR_ADDR: begin
                    if (byte_ok && !addr_bad) addr_latch_next = RX_P_DATA[ADDR_WIDTH-1:0];
                end
                S_WR_DATA: begin
                    if (byte_ok) begin
                        rf_wr_en_next   = 1'b1;
                        rf_addr_next    = addr_latch_reg;
                        rf_wr_data_next = RX_P_DATA;
                        hold_next       = ACK_BYTE;
                    end
                end
                S_RD_ADDR: begin
                    if (byte_ok && !addr_bad) begin
                        rf_rd_en_next = 1'b1;
                        rf_addr_next  = RX_P_DATA[ADDR_WIDTH-1:0];
                    end
                end
                S_RD_WAIT: begin
                    if (RF_RD_VLD && !rf_rd_en_reg) hold_next = RF_RD_DATA;
                end
                S_TX_SEND: begin
                    if (!TX_FULL) begin
                        tx_wr_en_next  = 1'b1;
                        tx_p_data_next = hold_reg;
                    end
                end
                default: ;
            endcase
        end
    end

    // Registered outputs
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            rf_addr_reg    <= '0;
            rf_wr_en_reg   <= 1'b0;
            rf_wr_data_reg <= '0;
            rf_rd_en_reg   <= 1'b0;
            tx_p_data_reg  <= '0;
            tx_wr_en_reg   <= 1'b0;
            busy_reg       <= 1'b0;
            err_cnt_reg    <= '0;
        end else begin
            rf_addr_reg    <= rf_addr_next;
            rf_wr_en_reg   <= rf_wr_en_next;
            rf_wr_data_reg <= rf_wr_data_next;
            rf_rd_en_reg   <= rf_rd_en_next;
            tx_p_data_reg  <= tx_p_data_next;
            tx_wr_en_reg   <= tx_wr_en_next;
            busy_reg       <= busy_next;
            err_cnt_reg    <= err_cnt_next;
        end
    end

    assign RF_ADDR    = rf_addr_reg;
    assign RF_WR_EN   = rf_wr_en_reg;
    assign RF_WR_DATA = rf_wr_data_reg;
    assign RF_RD_EN   = rf_rd_en_reg;
    assign TX_P_DATA  = tx_p_data_reg;
    assign TX_WR_EN   = tx_wr_en_reg;
    assign BUSY       = busy_reg;
    assign ERR_CNT    = err_cnt_reg;

endmodule

// File: tb/tb_uart_cmd_ctrl.sv
// Directed bench for uart_cmd_ctrl: a table of single commands plus
// hand-written sequences for backpressure, timeout, overrun, saturation and
// reset in the middle of a command.
module tb_uart_cmd_ctrl;

    localparam int TMO = 20;

    logic       CLK = 1'b0;
    logic       RST = 1'b0;
    logic [7:0] RX_P_DATA = 8'h00;
    logic       RX_D_VLD = 1'b0;
    logic       RX_PAR_ERR = 1'b0;
    logic       RX_STP_ERR = 1'b0;
    logic [3:0] RF_ADDR;
    logic       RF_WR_EN;
    logic [7:0] RF_WR_DATA;
    logic       RF_RD_EN;
    logic [7:0] RF_RD_DATA;
    logic       RF_RD_VLD;
    logic       TX_FULL = 1'b0;
    logic [7:0] TX_P_DATA;
    logic       TX_WR_EN;
    logic       BUSY;
    logic [7:0] ERR_CNT;

    uart_cmd_ctrl #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .TIMEOUT(TMO)) dut (
        .CLK(CLK), .RST(RST),
        .RX_P_DATA(RX_P_DATA), .RX_D_VLD(RX_D_VLD),
        .RX_PAR_ERR(RX_PAR_ERR), .RX_STP_ERR(RX_STP_ERR),
        .RF_ADDR(RF_ADDR), .RF_WR_EN(RF_WR_EN), .RF_WR_DATA(RF_WR_DATA),
        .RF_RD_EN(RF_RD_EN), .RF_RD_DATA(RF_RD_DATA), .RF_RD_VLD(RF_RD_VLD),
        .TX_FULL(TX_FULL), .TX_P_DATA(TX_P_DATA), .TX_WR_EN(TX_WR_EN),
        .BUSY(BUSY), .ERR_CNT(ERR_CNT)
    );

    always #5 CLK = ~CLK;

    // Register-file model: one-cycle read latency, data = 0x75 + address
    logic       rf_auto = 1'b1;
    logic       man_vld = 1'b0;
    logic [7:0] man_data = 8'h00;
    logic       rf_vld_q = 1'b0;
    logic [7:0] rf_data_q = 8'h00;
    always @(posedge CLK) begin
        rf_vld_q  <= (rf_auto & RF_RD_EN) | man_vld;
        rf_data_q <= man_vld ? man_data : (8'h75 + {4'h0, RF_ADDR});
    end
    assign RF_RD_VLD  = rf_vld_q;
    assign RF_RD_DATA = rf_data_q;

    // Strobe monitor, sampled mid-cycle
    int         wr_seen = 0, rd_seen = 0, tx_seen = 0;
    logic [3:0] wr_addr_seen = 4'h0, rd_addr_seen = 4'h0;
    logic [7:0] wr_data_seen = 8'h00, tx_data_seen = 8'h00;
    always @(negedge CLK) begin
        if (RF_WR_EN) begin
            wr_seen++;
            wr_addr_seen = RF_ADDR;
            wr_data_seen = RF_WR_DATA;
        end
        if (RF_RD_EN) begin
            rd_seen++;
            rd_addr_seen = RF_ADDR;
        end
        if (TX_WR_EN) begin
            tx_seen++;
            tx_data_seen = TX_P_DATA;
        end
    end

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic send(input logic [7:0] b, input logic pe, input logic se);
        RX_P_DATA  = b;
        RX_D_VLD   = 1'b1;
        RX_PAR_ERR = pe;
        RX_STP_ERR = se;
        @(posedge CLK);
        #1;
        RX_D_VLD   = 1'b0;
        RX_PAR_ERR = 1'b0;
        RX_STP_ERR = 1'b0;
    endtask

    typedef struct {
        string      name;
        int         nbytes;
        logic [7:0] b0, b1, b2;
        logic       pe_last;
        logic       se_last;
        int         exp_wr, exp_rd, exp_tx, exp_err;
        logic [3:0] exp_addr;
        logic [7:0] exp_wdata, exp_tx_data;
    } vec_t;

    vec_t vecs[9];
    int   exp_err = 0;
    int   w0, r0, t0;

    initial begin
        //            name        n  b0     b1     b2     pe  se  wr rd tx err addr  wdata  txdata
        vecs[0] = '{"write5",     3, 8'hAA, 8'h05, 8'h3C, 0, 0, 1, 0, 1, 0, 4'h5, 8'h3C, 8'h5A};
        vecs[1] = '{"read2",      2, 8'hBB, 8'h02, 8'h00, 0, 0, 0, 1, 1, 0, 4'h2, 8'h00, 8'h77};
        vecs[2] = '{"unknown",    1, 8'h11, 8'h00, 8'h00, 0, 0, 0, 0, 0, 1, 4'h0, 8'h00, 8'h00};
        vecs[3] = '{"rd_oor",     2, 8'hBB, 8'h20, 8'h00, 0, 0, 0, 0, 0, 1, 4'h0, 8'h00, 8'h00};
        vecs[4] = '{"wr_parerr",  3, 8'hAA, 8'h01, 8'h99, 1, 0, 0, 0, 0, 1, 4'h0, 8'h00, 8'h00};
        vecs[5] = '{"wr_oor",     2, 8'hAA, 8'h10, 8'h00, 0, 0, 0, 0, 0, 1, 4'h0, 8'h00, 8'h00};
        vecs[6] = '{"writeF",     3, 8'hAA, 8'h0F, 8'hFF, 0, 0, 1, 0, 1, 0, 4'hF, 8'hFF, 8'h5A};
        vecs[7] = '{"readF",      2, 8'hBB, 8'h0F, 8'h00, 0, 0, 0, 1, 1, 0, 4'hF, 8'h00, 8'h84};
        vecs[8] = '{"idle_stperr",1, 8'hAA, 8'h00, 8'h00, 0, 1, 0, 0, 0, 1, 4'h0, 8'h00, 8'h00};

        // Reset state
        idle(2);
        chk("rst_busy", int'(BUSY), 0);
        chk("rst_err", int'(ERR_CNT), 0);
        chk("rst_strobes", int'({RF_WR_EN, RF_RD_EN, TX_WR_EN}), 0);
        chk("rst_data", int'({RF_ADDR, RF_WR_DATA, TX_P_DATA}), 0);
        RST = 1'b1;
        idle(2);

        // Table of single commands, bytes back to back
        for (int i = 0; i < 9; i++) begin
            w0 = wr_seen; r0 = rd_seen; t0 = tx_seen;
            for (int k = 0; k < vecs[i].nbytes; k++) begin
                logic last;
                last = (k == vecs[i].nbytes - 1);
                send(k == 0 ? vecs[i].b0 : (k == 1 ? vecs[i].b1 : vecs[i].b2),
                     last & vecs[i].pe_last, last & vecs[i].se_last);
            end
            idle(8);
            exp_err += vecs[i].exp_err;
            chk({vecs[i].name, "_wr"}, wr_seen - w0, vecs[i].exp_wr);
            chk({vecs[i].name, "_rd"}, rd_seen - r0, vecs[i].exp_rd);
            chk({vecs[i].name, "_tx"}, tx_seen - t0, vecs[i].exp_tx);
            chk({vecs[i].name, "_err"}, int'(ERR_CNT), exp_err);
            chk({vecs[i].name, "_busy"}, int'(BUSY), 0);
            if (vecs[i].exp_wr != 0) begin
                chk({vecs[i].name, "_waddr"}, int'(wr_addr_seen), int'(vecs[i].exp_addr));
                chk({vecs[i].name, "_wdata"}, int'(wr_data_seen), int'(vecs[i].exp_wdata));
            end
            if (vecs[i].exp_rd != 0)
                chk({vecs[i].name, "_raddr"}, int'(rd_addr_seen), int'(vecs[i].exp_addr));
            if (vecs[i].exp_tx != 0)
                chk({vecs[i].name, "_txdata"}, int'(tx_data_seen), int'(vecs[i].exp_tx_data));
        end

        // Read with TX backpressure
        TX_FULL = 1'b1;
        r0 = rd_seen; t0 = tx_seen;
        send(8'hBB, 0, 0);
        send(8'h02, 0, 0);
        idle(TMO + 10);
        chk("bp_rd", rd_seen - r0, 1);
        chk("bp_raddr", int'(rd_addr_seen), 2);
        chk("bp_no_tx", tx_seen - t0, 0);
        chk("bp_busy", int'(BUSY), 1);
        chk("bp_err", int'(ERR_CNT), exp_err);
        TX_FULL = 1'b0;
        idle(6);
        chk("bp_tx", tx_seen - t0, 1);
        chk("bp_txdata", int'(tx_data_seen), 8'h77);
        chk("bp_busy_end", int'(BUSY), 0);

        // Timeout in WR_ADDR, then a normal write
        send(8'hAA, 0, 0);
        idle(TMO - 1);
        chk("tmo_not_early", int'(BUSY), 1);
        chk("tmo_err_early", int'(ERR_CNT), exp_err);
        idle(4);
        exp_err++;
        chk("tmo_busy", int'(BUSY), 0);
        chk("tmo_err", int'(ERR_CNT), exp_err);
        w0 = wr_seen; t0 = tx_seen;
        send(8'hAA, 0, 0);
        send(8'h01, 0, 0);
        send(8'h02, 0, 0);
        idle(6);
        chk("post_tmo_wr", wr_seen - w0, 1);
        chk("post_tmo_waddr", int'(wr_addr_seen), 1);
        chk("post_tmo_wdata", int'(wr_data_seen), 2);
        chk("post_tmo_tx", int'(tx_data_seen), 8'h5A);
        chk("post_tmo_err", int'(ERR_CNT), exp_err);

        // Overrun while waiting for read data
        rf_auto = 1'b0;
        t0 = tx_seen;
        send(8'hBB, 0, 0);
        send(8'h03, 0, 0);
        idle(2);
        send(8'h44, 0, 0);
        idle(1);
        exp_err++;
        chk("ovr_err", int'(ERR_CNT), exp_err);
        chk("ovr_busy", int'(BUSY), 1);
        man_data = 8'h99;
        man_vld  = 1'b1;
        idle(1);
        man_vld  = 1'b0;
        idle(6);
        rf_auto  = 1'b1;
        chk("ovr_tx", tx_seen - t0, 1);
        chk("ovr_txdata", int'(tx_data_seen), 8'h99);
        chk("ovr_busy_end", int'(BUSY), 0);

        // Saturation of the error counter
        for (int i = 0; i < 300; i++) send(8'h11, 1, 0);
        idle(2);
        chk("sat_err", int'(ERR_CNT), 255);

        // Reset in the middle of a write command
        w0 = wr_seen; t0 = tx_seen;
        send(8'hAA, 0, 0);
        send(8'h03, 0, 0);
        RST = 1'b0;
        idle(2);
        RST = 1'b1;
        #1;
        chk("mrst_outs", int'({RF_ADDR, RF_WR_EN, RF_RD_EN, TX_WR_EN, BUSY}), 0);
        chk("mrst_data", int'({RF_WR_DATA, TX_P_DATA}), 0);
        chk("mrst_err", int'(ERR_CNT), 0);
        idle(TMO + 5);
        chk("mrst_no_strobe", (wr_seen - w0) + (tx_seen - t0), 0);
        send(8'h33, 0, 0);
        idle(3);
        chk("mrst_unknown", int'(ERR_CNT), 1);
        chk("mrst_busy", int'(BUSY), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    // Hard stop in case anything stalls
    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
